// File: rtl/dds_pkg.sv
// dds_pkg: waveform/FSM encodings and gain constants shared across the DDS datapath
package dds_pkg;

    typedef enum logic [2:0] {
        MODEL_SINE   = 3'b000,
        MODEL_SQUARE = 3'b001,
        MODEL_TRI    = 3'b010,
        MODEL_SAW    = 3'b011
    } model_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } sweep_state_e;

    localparam int AMP_UNITY = 256;

    function automatic logic [8:0] amp_sat(input logic [8:0] a);
        return a > 9'(AMP_UNITY) ? 9'(AMP_UNITY) : a;
    endfunction

endpackage

// File: rtl/dds_sine_qlut.sv
// dds_sine_qlut: quarter-wave sine ROM with half-sample offset so mirroring needs only bit inversion
module dds_sine_qlut #(
    parameter int PHASE_W = 12,
    parameter int DATA_W  = 14
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [PHASE_W-3:0] Addr,
    output logic [DATA_W-2:0]  Q
);

    localparam int  DEPTH = 2 ** (PHASE_W - 2);
    localparam real PEAK  = real'(2 ** (DATA_W - 1) - 1);
    localparam real PI    = 3.141592653589793;

    logic [DATA_W-2:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam int V = $rtoi(PEAK * $sin(2.0 * PI * (real'(k) + 0.5) / real'(2 ** PHASE_W)) + 0.5);
        assign rom[k] = (DATA_W-1)'(V);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) Q <= '0;
        else Q <= rom[Addr];
    end

endmodule

// File: rtl/dds_sweep_gen.sv
// dds_sweep_gen: DDS source with linear frequency sweep, amplitude scaling and five waveform modes
module dds_sweep_gen
    import dds_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 12,
    parameter int DATA_W  = 14,
    parameter int DWELL_W = 16
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Cfg_load,
    input  logic               Acc_clr,
    input  logic [2:0]         Model_sel,
    input  logic [ACC_W-1:0]   Fword_start,
    input  logic [ACC_W-1:0]   Fword_stop,
    input  logic [ACC_W-1:0]   Fword_step,
    input  logic [DWELL_W-1:0] Dwell,
    input  logic               Sweep_en,
    input  logic               Sweep_rpt,
    input  logic [PHASE_W-1:0] Pword,
    input  logic [8:0]         Amp,
    output logic [DATA_W-1:0]  Data,
    output logic               Data_valid,
    output logic               Sweep_busy,
    output logic               Sweep_done
);

    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] FS = '1;
    localparam int PROD_W = DATA_W + 11;

    logic [2:0]         sel_r;
    logic [ACC_W-1:0]   start_r, stop_r, step_r;
    logic [DWELL_W-1:0] dwell_r;
    logic               rpt_r;
    logic [PHASE_W-1:0] pword_r;
    logic [8:0]         amp_r;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sel_r   <= '0;
            start_r <= '0;
            stop_r  <= '0;
            step_r  <= '0;
            dwell_r <= '0;
            rpt_r   <= 1'b0;
            pword_r <= '0;
            amp_r   <= '0;
        end else if (Cfg_load) begin
            sel_r   <= Model_sel;
            start_r <= Fword_start;
            stop_r  <= Fword_stop;
            step_r  <= Fword_step;
            dwell_r <= Dwell;
            rpt_r   <= Sweep_rpt;
            pword_r <= Pword;
            amp_r   <= amp_sat(Amp);
        end
    end

    sweep_state_e       state, state_nx;
    logic [ACC_W-1:0]   fword_cur, cur_nx, acc, acc_nx, rem, stepped;
    logic [DWELL_W-1:0] dwell_cnt, cnt_nx;
    logic [1:0]         fill, fill_nx;
    logic               wrap, wrap_nx, done_nx, up, expire;

    // wrap marks a repeat sweep that just hit the stop word; its next expiry reloads the start word
    always_comb begin
        up       = stop_r >= start_r;
        rem      = up ? stop_r - fword_cur : fword_cur - stop_r;
        stepped  = step_r >= rem ? stop_r : up ? fword_cur + step_r : fword_cur - step_r;
        expire   = dwell_cnt == dwell_r;
        acc_nx   = (Cfg_load && Acc_clr) ? '0 : acc + fword_cur;
        fill_nx  = Cfg_load ? 2'd0 : fill == 2'd3 ? fill : fill + 2'd1;
        state_nx = state;
        cur_nx   = fword_cur;
        cnt_nx   = dwell_cnt;
        wrap_nx  = wrap;
        done_nx  = 1'b0;
        if (Cfg_load) begin
            state_nx = (Sweep_en && Fword_step != '0) ? ST_RUN : ST_IDLE;
            cur_nx   = Fword_start;
            cnt_nx   = '0;
            wrap_nx  = 1'b0;
        end else if (state == ST_RUN) begin
            cnt_nx = expire ? '0 : dwell_cnt + DWELL_W'(1);
            if (expire) begin
                cur_nx   = wrap ? start_r : stepped;
                done_nx  = !wrap && stepped == stop_r;
                wrap_nx  = done_nx && rpt_r;
                state_nx = (done_nx && !rpt_r) ? ST_HOLD : ST_RUN;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= ST_IDLE;
            fword_cur  <= '0;
            dwell_cnt  <= '0;
            wrap       <= 1'b0;
            Sweep_done <= 1'b0;
            acc        <= '0;
            fill       <= '0;
        end else begin
            state      <= state_nx;
            fword_cur  <= cur_nx;
            dwell_cnt  <= cnt_nx;
            wrap       <= wrap_nx;
            Sweep_done <= done_nx;
            acc        <= acc_nx;
            fill       <= fill_nx;
        end
    end

    assign Sweep_busy = state == ST_RUN;
    assign Data_valid = fill == 2'd3;

    logic [PHASE_W-1:0] p_r;
    logic [PHASE_W-2:0] tri_v;
    logic [PHASE_W-3:0] lut_addr;
    logic [DATA_W-2:0]  lut_q;
    logic [DATA_W-1:0]  wave_nx, wave_r, raw, data_nx;
    logic               neg_r, sine_r;
    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] dx, ax, prod, sum;

    always_comb begin
        lut_addr = p_r[PHASE_W-2] ? ~p_r[PHASE_W-3:0] : p_r[PHASE_W-3:0];
        tri_v    = p_r[PHASE_W-1] ? ~p_r[PHASE_W-2:0] : p_r[PHASE_W-2:0];
        wave_nx  = sel_r[2] ? MID :
                   sel_r == MODEL_SQUARE ? (p_r[PHASE_W-1] ? '0 : FS) :
                   sel_r == MODEL_TRI ? DATA_W'(tri_v) << (DATA_W - PHASE_W + 1) :
                   sel_r == MODEL_SAW ? DATA_W'(p_r) << (DATA_W - PHASE_W) : MID;
        raw      = sine_r ? (neg_r ? MID - DATA_W'(1) - DATA_W'(lut_q) : MID + DATA_W'(lut_q)) : wave_r;
        diff     = $signed({1'b0, raw}) - $signed({1'b0, MID});
        dx       = diff;
        ax       = PROD_W'(amp_r);
        prod     = dx * ax;
        sum      = (prod >>> 8) + PROD_W'(MID);
        data_nx  = DATA_W'(sum);
    end

    dds_sine_qlut #(
        .PHASE_W(PHASE_W),
        .DATA_W (DATA_W)
    ) u_qlut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .Addr   (lut_addr),
        .Q      (lut_q)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            p_r    <= '0;
            wave_r <= '0;
            neg_r  <= 1'b0;
            sine_r <= 1'b0;
            Data   <= '0;
        end else begin
            p_r    <= acc[ACC_W-1 -: PHASE_W] + pword_r;
            wave_r <= wave_nx;
            neg_r  <= p_r[PHASE_W-1];
            sine_r <= sel_r == MODEL_SINE;
            Data   <= data_nx;
        end
    end

endmodule

// File: tb/tb_dds_sweep_gen.sv
// tb_dds_sweep_gen: random and directed checks of dds_sweep_gen against a closed-form behavioural model
module tb_dds_sweep_gen;

    localparam int ACC_W = 32, PHASE_W = 12, DATA_W = 14, DWELL_W = 16;
    localparam int N = 4096, H = 2048, MID = 8192, FS = 16383;
    localparam real PI = 3.141592653589793;

    logic               Clk = 1'b0, Reset_n = 1'b0, Cfg_load = 1'b0, Acc_clr = 1'b0;
    logic [2:0]         Model_sel = '0;
    logic [ACC_W-1:0]   Fword_start = '0, Fword_stop = '0, Fword_step = '0;
    logic [DWELL_W-1:0] Dwell = '0;
    logic               Sweep_en = 1'b0, Sweep_rpt = 1'b0;
    logic [PHASE_W-1:0] Pword = '0;
    logic [8:0]         Amp = '0;
    logic [DATA_W-1:0]  Data;
    logic               Data_valid, Sweep_busy, Sweep_done;

    always #5 Clk = ~Clk;

    dds_sweep_gen #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .DATA_W(DATA_W), .DWELL_W(DWELL_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Cfg_load(Cfg_load), .Acc_clr(Acc_clr), .Model_sel(Model_sel),
        .Fword_start(Fword_start), .Fword_stop(Fword_stop), .Fword_step(Fword_step), .Dwell(Dwell),
        .Sweep_en(Sweep_en), .Sweep_rpt(Sweep_rpt), .Pword(Pword), .Amp(Amp),
        .Data(Data), .Data_valid(Data_valid), .Sweep_busy(Sweep_busy), .Sweep_done(Sweep_done)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // model state: accumulator, current word, cycles since load, captured configuration
    logic [31:0] m_acc, m_cur;
    logic [31:0] h [4];
    int          m_k, m_fill, c_dwell, c_pw, c_amp;
    bit          m_busy, m_done, c_rpt;
    longint      c_start, c_stop, c_step;
    logic [2:0]  c_sel;

    function automatic int exp_data(input logic [31:0] acc, input logic [2:0] sel, input int pw, input int amp);
        int  p, raw, l, a, prod, q;
        real s;
        p = (int'(acc >> (ACC_W - PHASE_W)) + pw) % N;
        s = $sin(2.0 * PI * (real'(p) + 0.5) / real'(N));
        l = $rtoi(real'(MID - 1) * (s < 0.0 ? -s : s) + 0.5);
        if (sel[2]) raw = MID;
        else case (sel[1:0])
            2'd0:    raw = s >= 0.0 ? MID + l : MID - 1 - l;
            2'd1:    raw = p < H ? FS : 0;
            2'd2:    raw = (p < H ? p : N - 1 - p) * 8;
            default: raw = p * 4;
        endcase
        a = amp > 256 ? 256 : amp;
        prod = (raw - MID) * a;
        q = prod / 256;
        if (prod < 0 && prod % 256 != 0) q = q - 1;
        return MID + q;
    endfunction

    function automatic longint dist_of(input longint st, input longint sp);
        return sp >= st ? sp - st : st - sp;
    endfunction

    function automatic longint n_steps(input longint st, input longint sp, input longint stp);
        longint d = dist_of(st, sp);
        return d == 0 ? 1 : (d + stp - 1) / stp;
    endfunction

    function automatic longint sw_pos(input longint st, input longint sp, input longint stp, input longint j);
        longint mv = j * stp > dist_of(st, sp) ? dist_of(st, sp) : j * stp;
        return sp >= st ? st + mv : st - mv;
    endfunction

    task automatic m_reset();
        m_acc = '0; m_cur = '0; m_k = 0; m_fill = 0; m_busy = 0; m_done = 0;
        c_start = 0; c_stop = 0; c_step = 0; c_dwell = 0; c_rpt = 0; c_sel = '0; c_pw = 0; c_amp = 0;
        for (int i = 0; i < 4; i++) h[i] = '0;
    endtask

    task automatic m_edge();
        logic [31:0] na;
        longint ns, j;
        m_done = 0;
        if (Cfg_load) begin
            na = Acc_clr ? 32'd0 : m_acc + m_cur;
            m_cur = Fword_start; m_k = 0; m_fill = 0;
            m_busy = Sweep_en && Fword_step != 0;
            c_start = Fword_start; c_stop = Fword_stop; c_step = Fword_step; c_dwell = Dwell;
            c_rpt = Sweep_rpt; c_sel = Model_sel; c_pw = Pword; c_amp = Amp;
        end else begin
            na = m_acc + m_cur;
            m_fill = m_fill == 3 ? 3 : m_fill + 1;
            if (m_busy) begin
                m_k++;
                if (m_k % (c_dwell + 1) == 0) begin
                    ns = n_steps(c_start, c_stop, c_step);
                    j = m_k / (c_dwell + 1);
                    if (c_rpt) j = j % (ns + 1);
                    m_cur = 32'(sw_pos(c_start, c_stop, c_step, j));
                    m_done = j == ns;
                    if (m_done && !c_rpt) m_busy = 0;
                end
            end
        end
        m_acc = na;
        for (int i = 3; i > 0; i--) h[i] = h[i-1];
        h[0] = na;
    endtask

    task automatic tick();
        m_edge();
        @(posedge Clk);
        #1;
        chk("valid", Data_valid, m_fill == 3);
        chk("busy", Sweep_busy, m_busy);
        chk("done", Sweep_done, m_done);
        if (m_fill == 3) chk("data", Data, exp_data(h[3], c_sel, c_pw, c_amp));
    endtask

    task automatic load(input bit clr, input bit en, input bit rpt, input logic [2:0] sel,
                        input logic [31:0] st, input logic [31:0] sp, input logic [31:0] stp,
                        input int dw, input int pw, input int amp);
        Acc_clr = clr; Sweep_en = en; Sweep_rpt = rpt; Model_sel = sel;
        Fword_start = st; Fword_stop = sp; Fword_step = stp; Dwell = 16'(dw);
        Pword = 12'(pw); Amp = 9'(amp);
        Cfg_load = 1'b1;
        tick();
        Cfg_load = 1'b0;
        // scramble the config inputs: they must be ignored until the next load
        Acc_clr = 1'($urandom); Sweep_en = 1'($urandom); Sweep_rpt = 1'($urandom); Model_sel = 3'($urandom);
        Fword_start = $urandom; Fword_stop = $urandom; Fword_step = $urandom; Dwell = 16'($urandom);
        Pword = 12'($urandom); Amp = 9'($urandom);
    endtask

    initial begin
        int mx, mn, nd, td;
        m_reset();
        #12;
        chk("rst_data", Data, 0);
        chk("rst_valid", Data_valid, 0);
        chk("rst_busy", Sweep_busy, 0);
        chk("rst_done", Sweep_done, 0);
        Reset_n = 1'b1;
        repeat (4) tick();

        load(1, 0, 0, 3'b000, 32'h0010_0000, 0, 0, 0, 0, 256);
        mx = 0; mn = FS;
        repeat (4100) begin
            tick();
            if (m_fill == 3) begin
                mx = Data > mx ? Data : mx;
                mn = Data < mn ? Data : mn;
            end
        end
        chk("sine_peak", mx, 16383);
        chk("sine_trough", mn, 0);

        load(1, 0, 0, 3'b001, 32'h0010_0000, 0, 0, 0, 2048, 128);
        tick(); tick(); tick();
        chk("sq_inverted_first", Data, 4096);
        mx = 0; mn = FS;
        repeat (4100) begin
            tick();
            mx = Data > mx ? Data : mx;
            mn = Data < mn ? Data : mn;
        end
        chk("sq_hi", mx, 12287);
        chk("sq_lo", mn, 4096);

        load(1, 1, 0, 3'b000, 100, 130, 10, 3, 0, 256);
        nd = 0; td = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (Sweep_done) begin nd++; td = i; end
        end
        chk("up_done_cnt", nd, 1);
        chk("up_done_at", td, 12);
        chk("up_hold_busy", Sweep_busy, 0);

        load(0, 1, 1, 3'b010, 130, 100, 20, 1, 0, 256);
        nd = 0; td = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (Sweep_done) begin
                nd++;
                if (td == 0) td = i;
            end
        end
        chk("dn_done_cnt", nd, 3);
        chk("dn_first_done", td, 4);
        chk("dn_rpt_busy", Sweep_busy, 1);

        load(0, 1, 0, 3'b100, 500, 900, 0, 0, 0, 100);
        repeat (6) tick();
        chk("idle_busy", Sweep_busy, 0);
        chk("mid_data", Data, 8192);

        load(1, 1, 1, 3'b000, 32'h0100_0000, 32'h4000_0000, 32'h0400_0000, 2, 77, 256);
        repeat (10) tick();
        #2 Reset_n = 1'b0;
        #1;
        chk("mrst_data", Data, 0);
        chk("mrst_valid", Data_valid, 0);
        chk("mrst_busy", Sweep_busy, 0);
        chk("mrst_done", Sweep_done, 0);
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        m_reset();
        repeat (3) tick();
        chk("mrst_valid_3", Data_valid, 1);
        repeat (5) tick();

        for (int r = 0; r < 14; r++) begin
            logic [31:0] st, sp, stp;
            st = $urandom;
            sp = ($urandom_range(0, 1) == 1) ? $urandom : st + 32'($urandom_range(0, 32'h0800_0000)) - 32'h0400_0000;
            stp = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom_range(32'h0010_0000, 32'h1000_0000);
            load(1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom_range(0, 7)),
                 st, sp, stp, $urandom_range(0, 4), $urandom_range(0, 4095), $urandom_range(0, 511));
            repeat ($urandom_range(150, 400)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_sweep_gen.md
# dds_sweep_gen

Parametrised DDS waveform generator with a built-in linear frequency sweep engine, amplitude scaling and five output modes. It is the next-generation signal source in the DDS datapath, driving the DAC sample bus. Phase continuity is kept across frequency changes. The sine wave is generated from a quarter-wave LUT rather than full-period ROMs.

## Interface
- ACC_W, 32: phase accumulator width.
- PHASE_W, 12: phase/LUT address width; legal range 4 ≤ PHASE_W ≤ DATA_W.
- DATA_W, 14: output sample width, offset-binary; MID = 2^(DATA_W-1).
- DWELL_W, 16: dwell counter width.

Ports:
- Clk  in  1  clock.
- Reset_n  in  1  reset, asynchronous, active-low.
- Cfg_load  in  1  single-cycle pulse; captures all Cfg inputs below.
- Acc_clr  in  1  sampled with Cfg_load; clears the accumulator.
- Model_sel  in  3  waveform select: 000 sine, 001 square, 010 triangle, 011 sawtooth, 1xx MID.
- Fword_start  in  ACC_W  sweep start / fixed frequency word.
- Fword_stop  in  ACC_W  sweep end word.
- Fword_step  in  ACC_W  unsigned step magnitude.
- Dwell  in  DWELL_W  extra cycles per step; a step lasts Dwell+1 cycles.
- Sweep_en  in  1  enable sweep.
- Sweep_rpt  in  1  0: single sweep; 1: repeat sweep.
- Pword  in  PHASE_W  phase offset; full range maps to 0..2π.
- Amp  in  9  gain; 256 = unity, values above 256 saturate to 256.
- Data  out  DATA_W  sample output.
- Data_valid  out  1  Data reflects the current configuration.
- Sweep_busy  out  1  FSM in RUN.
- Sweep_done  out  1  one-cycle pulse when the current frequency word reaches Fword_stop.

## Operation
- **Configuration registers:** all Cfg inputs are ignored except on the Cfg_load edge.
- **Effects of Cfg_load:**
  - Fword_cur ← Fword_start.
  - Dwell counter ← 0.
  - FSM → RUN if Sweep_en and Fword_step ≠ 0; otherwise FSM → IDLE.
  - Data_valid ← 0.
  - A Cfg_load during RUN or HOLD restarts the sweep.
- **Accumulator:** Freq_ACC += Fword_cur every cycle, modulo 2^ACC_W. Acc_clr sets Freq_ACC to 0 on the load edge.
- **Phase:** p = Freq_ACC[ACC_W-1 -: PHASE_W] + Pword, modulo 2^PHASE_W.
- **Sweep direction:** up if Fword_stop ≥ Fword_start, down otherwise.
- **FSM states:**
  - IDLE: Fword_cur held.
  - RUN: at each dwell expiry, Fword_cur moves by Fword_step toward Fword_stop.
    - Overshoot clamps to Fword_stop.
    - Reaching Fword_stop pulses Sweep_done.
    - Single mode: RUN→HOLD.
    - Repeat mode: stay in RUN; the next dwell expiry loads Fword_start.
  - HOLD: Fword_cur = Fword_stop; leave only on Cfg_load.
  - Fword_start == Fword_stop: done on the first expiry.
- **Waveforms (offset-binary, FS = 2^DATA_W-1):**
  - Square: p MSB 0 → FS; p MSB 1 → 0.
  - Sawtooth: {p, zeros}, left-aligned to DATA_W bits.
  - Triangle: t = MSB ? ~p[PHASE_W-2:0] : p[PHASE_W-2:0]; output {t, zeros}, left-aligned.
  - Sine: a = p[PHASE_W-3:0], mirrored when p[PHASE_W-2]=1.
    - Positive half: MID + L[a].
    - Negative half (p MSB=1): MID-1-L[a].
    - LUT entry L[k] = round((MID-1)·sin(2π(k+0.5)/2^PHASE_W)).
- **Scaling:** Data = MID + ((raw−MID)·Amp) >>> 8, with signed arithmetic and an arithmetic right shift (rounds toward −∞). Amp=0 gives Data = MID.

## Timing
- **Reset values:**
  - Data: 0.
  - Data_valid, Sweep_busy, Sweep_done: 0.
  - Freq_ACC, Fword_cur, dwell counter, all config registers: 0.
  - FSM: IDLE.
- **Pipeline:** Freq_ACC@n → p@n+1 → raw@n+2 (registered LUT read) → Data@n+3. Latency is 3 cycles for all modes; modes are delay-matched.
- **Data_valid:** rises at the third edge after reset release or after Cfg_load; a 2-bit fill counter tracks this.
- **Sweep step edges:** with Cfg_load at edge n, Fword_cur steps at edges n+k(Dwell+1). Sweep_done and Sweep_busy update on the same edge Fword_cur reaches Fword_stop.
- **Reset mid-operation:** immediately forces the reset values above.

## Structure
- **Shared package dds_pkg** holds:
  - Model_sel encodings.
  - FSM state encoding (IDLE/RUN/HOLD).
  - AMP_UNITY = 256.
- **Sub-module dds_sine_qlut:**
  - Quarter-wave ROM: 2^(PHASE_W-2) × (DATA_W-1) bits.
  - 1-cycle registered read.
  - Contents generated at elaboration.

## Test plan
- **Defaults, sine, fixed word:** Fword_start=2^20, Amp=256, Pword=0, Acc_clr=1.
  - Data_valid rises 3 cycles after load.
  - Period is 4096 samples; peak 16383, trough 0.
- **Square, Pword=2048:** output is inverted relative to Pword=0. Amp=128 gives levels 12287 / 4096.
- **Single up-sweep:** start=100, stop=130, step=10, Dwell=3.
  - Fword_cur steps 110/120/130 at +4/+8/+12 cycles.
  - Sweep_done pulses once at +12; then HOLD with Sweep_busy=0.
- **Repeat down-sweep with clamp:** start=130, stop=100, step=20. Expect 110 then 100 (clamped), Sweep_done, then 130 again.
- **Fword_step=0 with Sweep_en=1:** FSM stays in IDLE and Sweep_busy stays 0. Model_sel=100 gives Data=8192.
- **Reset asserted mid-sweep:** all outputs go to 0 immediately. After release, Data_valid rises after 3 edges.
